alu_arbiter: RTL and testbench

Shares one combinational ALU between two requesters (e.g. integer execute path and address/branch-compare path) with valid/ready handshakes on both request and response sides. Grant is round-robin or fixed-priority. The winning operands drive the ALU and the result is captured in a single tagged result register. The result is returned to the owning requester one cycle after acceptance and held until that requester takes it.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu.sv | 35 +++
 rtl/rr_arb2.sv | 25 ++
 rtl/alu_arbiter.sv | 98 +++++++++
 tb/tb_alu_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op codes and the result-slot types used by the arbitrated ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef logic req_id_t;

    typedef struct packed {
        logic        valid;
        req_id_t     id;
        logic [31:0] out;
        logic        zero;
    } res_slot_t;

endpackage

// File: rtl/alu.sv
// Fixed 32-bit combinational ALU; unknown op codes give zero.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]  ctrl,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] out,
    output logic        zero
);

    logic [4:0] shamt;

    assign shamt = in2[4:0];

    always_comb begin
        out = '0;
        case (ctrl)
            ALU_ADD:  out = in1 + in2;
            ALU_SUB:  out = in1 - in2;
            ALU_SLL:  out = in1 << shamt;
            ALU_SLT:  out = {31'd0, $signed(in1) < $signed(in2)};
            ALU_SLTU: out = {31'd0, in1 < in2};
            ALU_XOR:  out = in1 ^ in2;
            ALU_SRL:  out = in1 >> shamt;
            ALU_SRA:  out = $unsigned($signed(in1) >>> shamt);
            ALU_OR:   out = in1 | in2;
            ALU_AND:  out = in1 & in2;
            default:  out = '0;
        endcase
    end

    assign zero = (out == '0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way grant: round-robin against last_grant, or fixed priority to 0.
module rr_arb2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    input  logic       prio_mode,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid0 && valid1) begin
                if (!prio_mode && !last_grant)
                    grant = 2'b10;
                else
                    grant = 2'b01;
            end else begin
                grant = {valid1, valid0};
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// One shared ALU behind two valid/ready requesters with a single tagged
// result slot that drains and refills in the same cycle.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int PRIO_MODE = 0,
    parameter int DATA_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    input  logic [3:0]  req0_ctrl,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_out,
    output logic        rsp0_zero,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    input  logic [3:0]  req1_ctrl,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_out,
    output logic        rsp1_zero
);

    if (DATA_W != 32) begin : g_bad_width
        $error("alu_arbiter: DATA_W must be 32");
    end

    res_slot_t   slot;
    req_id_t     last_grant;
    req_id_t     sel;
    logic [1:0]  grant;
    logic        owner_ready;
    logic        can_accept;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_out;
    logic        alu_zero;

    assign owner_ready = slot.id ? rsp1_ready : rsp0_ready;
    assign can_accept  = !slot.valid || owner_ready;

    rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .prio_mode  (PRIO_MODE != 0),
        .enable     (can_accept),
        .grant      (grant)
    );

    assign sel        = grant[1];
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign alu_ctrl = sel ? req1_ctrl : req0_ctrl;
    assign alu_in1  = sel ? req1_in1  : req0_in1;
    assign alu_in2  = sel ? req1_in2  : req0_in2;

    alu u_alu (
        .ctrl (alu_ctrl),
        .in1  (alu_in1),
        .in2  (alu_in2),
        .out  (alu_out),
        .zero (alu_zero)
    );

    // An accept overrides the drain: that is the same-cycle refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot       <= '0;
            last_grant <= 1'b1;
        end else if (|grant) begin
            slot.valid <= 1'b1;
            slot.id    <= sel;
            slot.out   <= alu_out;
            slot.zero  <= alu_zero;
            last_grant <= sel;
        end else if (slot.valid && owner_ready) begin
            slot.valid <= 1'b0;
        end
    end

    assign rsp0_valid = slot.valid && !slot.id;
    assign rsp1_valid = slot.valid && slot.id;
    assign rsp0_out   = rsp0_valid ? slot.out : '0;
    assign rsp1_out   = rsp1_valid ? slot.out : '0;
    assign rsp0_zero  = rsp0_valid && slot.zero;
    assign rsp1_zero  = rsp1_valid && slot.zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        rsp0_valid, rsp0_ready, rsp0_zero;
    logic        rsp1_valid, rsp1_ready, rsp1_zero;
    logic [31:0] rsp0_out, rsp1_out;
    logic        p_req0_ready, p_req1_ready;
    logic        p_rsp0_valid, p_rsp1_valid, p_rsp0_zero, p_rsp1_zero;
    logic [31:0] p_rsp0_out, p_rsp1_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.PRIO_MODE(0), .DATA_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_ctrl(req0_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_out(rsp0_out), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_ctrl(req1_ctrl),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_out(rsp1_out), .rsp1_zero(rsp1_zero)
    );

    alu_arbiter #(.PRIO_MODE(1), .DATA_W(32)) u_prio (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(p_req0_ready),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_ctrl(req0_ctrl),
        .rsp0_valid(p_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_out(p_rsp0_out), .rsp0_zero(p_rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(p_req1_ready),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_ctrl(req1_ctrl),
        .rsp1_valid(p_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_out(p_rsp1_out), .rsp1_zero(p_rsp1_zero)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct {
        bit          port;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        bit          zero;
    } vec_t;

    function automatic logic [31:0] ref_alu(input op_t o);
        logic signed [31:0] sa;
        int sh;
        sa = o.a;
        sh = int'(o.b[4:0]);
        case (o.ctrl)
            4'b0000: return o.a + o.b;
            4'b1000: return o.a - o.b;
            4'b0001: return o.a << sh;
            4'b0010: return ($signed(o.a) < $signed(o.b)) ? 32'd1 : 32'd0;
            4'b0011: return (o.a < o.b) ? 32'd1 : 32'd0;
            4'b0100: return o.a ^ o.b;
            4'b0101: return o.a >> sh;
            4'b1101: return sa >>> sh;
            4'b0110: return o.a | o.b;
            4'b0111: return o.a & o.b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit p, input logic v, input op_t o);
        if (!p) begin
            req0_valid = v; req0_ctrl = o.ctrl;
            req0_in1 = o.a; req0_in2 = o.b;
        end else begin
            req1_valid = v; req1_ctrl = o.ctrl;
            req1_in1 = o.a; req1_in2 = o.b;
        end
    endtask

    function automatic logic get_rdy(input bit p);
        return p ? req1_ready : req0_ready;
    endfunction

    function automatic logic get_rv(input bit p);
        return p ? rsp1_valid : rsp0_valid;
    endfunction

    function automatic logic [31:0] get_out(input bit p);
        return p ? rsp1_out : rsp0_out;
    endfunction

    function automatic logic get_zero(input bit p);
        return p ? rsp1_zero : rsp0_zero;
    endfunction

    function automatic op_t mk(input logic [3:0] c, input logic [31:0] a,
                               input logic [31:0] b);
        op_t o;
        o.ctrl = c; o.a = a; o.b = b;
        return o;
    endfunction

    task automatic do_reset();
        op_t idle;
        idle = mk(4'd0, 32'd0, 32'd0);
        tick();
        rst = 1'b1;
        set_req(0, 1'b0, idle);
        set_req(1, 1'b0, idle);
        tick();
        rst = 1'b0;
    endtask

    task automatic do_op(input vec_t v);
        op_t o;
        int n;
        o = mk(v.ctrl, v.a, v.b);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        tick();
        set_req(v.port, 1'b1, o);
        #4;
        n = 0;
        while (!get_rdy(v.port) && n < 10) begin
            tick();
            #4;
            n++;
        end
        chk("op_ready", get_rdy(v.port), 1);
        chk("op_ready_wait", n, 0);
        tick();
        set_req(v.port, 1'b0, o);
        #4;
        chk("op_rsp_valid", get_rv(v.port), 1);
        chk("op_rsp_out", get_out(v.port), v.out);
        chk("op_rsp_zero", get_zero(v.port), v.zero);
        chk("op_other_valid", get_rv(!v.port), 0);
    endtask

    function automatic op_t rand_op();
        logic [3:0] codes [10];
        op_t o;
        int k;
        codes = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                  4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
        k = $urandom_range(0, 11);
        if (k < 10) o.ctrl = codes[k];
        else if (k == 10) o.ctrl = 4'b1111;
        else o.ctrl = 4'($urandom_range(0, 15));
        o.a = $urandom;
        o.b = ($urandom_range(0, 3) == 0) ? o.a : $urandom;
        return o;
    endfunction

    vec_t vecs[$];
    op_t  ops0 [3];
    op_t  ops1 [3];

    initial begin
        op_t idle;
        idle = mk(4'd0, 32'd0, 32'd0);
        rst = 1'b1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        set_req(0, 1'b0, idle);
        set_req(1, 1'b0, idle);

        vecs.push_back('{0, 4'b0000, 32'd5, 32'd7, 32'd12, 0});
        vecs.push_back('{1, 4'b1000, 32'd3, 32'd3, 32'd0, 1});
        vecs.push_back('{1, 4'b1101, 32'h80000000, 32'd4, 32'hF8000000, 0});
        vecs.push_back('{0, 4'b0001, 32'd1, 32'd33, 32'd2, 0});
        vecs.push_back('{0, 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd1, 0});
        vecs.push_back('{0, 4'b0011, 32'hFFFFFFFF, 32'd1, 32'd0, 1});
        vecs.push_back('{1, 4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0,
                         32'hFF00FF00, 0});
        vecs.push_back('{1, 4'b0101, 32'h80000000, 32'd31, 32'd1, 0});
        vecs.push_back('{0, 4'b0110, 32'h00FF0000, 32'h000000FF,
                         32'h00FF00FF, 0});
        vecs.push_back('{1, 4'b0111, 32'hFF00FF00, 32'h0FF00FF0,
                         32'h0F000F00, 0});
        vecs.push_back('{0, 4'b0000, 32'hFFFFFFFF, 32'd1, 32'd0, 1});
        vecs.push_back('{0, 4'b1111, 32'd123, 32'd456, 32'd0, 1});
        vecs.push_back('{1, 4'b1000, 32'd0, 32'd1, 32'hFFFFFFFF, 0});

        // reset state
        tick();
        tick();
        rst = 1'b0;
        #4;
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp0_out", rsp0_out, 0);
        chk("rst_rsp1_out", rsp1_out, 0);
        chk("rst_rsp0_zero", rsp0_zero, 0);
        chk("rst_rsp1_zero", rsp1_zero, 0);

        foreach (vecs[i]) do_op(vecs[i]);

        // contention: both valid for four cycles
        ops0 = '{mk(4'b0000, 32'd10, 32'd20), mk(4'b0100, 32'hFF, 32'h0F),
                 mk(4'b0111, 32'hFF, 32'h3C)};
        ops1 = '{mk(4'b1000, 32'd100, 32'd1), mk(4'b0110, 32'h100, 32'h1),
                 mk(4'b0001, 32'd1, 32'd4)};
        do_reset();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        begin
            int i0, i1;
            bit have_prev, pp, g;
            logic [31:0] pe;
            i0 = 0; i1 = 0; have_prev = 0; pp = 0; pe = '0;
            for (int c = 0; c < 4; c++) begin
                tick();
                set_req(0, 1'b1, ops0[i0]);
                set_req(1, 1'b1, ops1[i1]);
                #4;
                g = c[0];
                chk("rr_ready0", req0_ready, !g);
                chk("rr_ready1", req1_ready, g);
                chk("prio_ready0", p_req0_ready, 1);
                chk("prio_ready1", p_req1_ready, 0);
                if (have_prev) begin
                    chk("rr_rsp_valid", get_rv(pp), 1);
                    chk("rr_rsp_out", get_out(pp), pe);
                    chk("rr_rsp_other", get_rv(!pp), 0);
                end
                pp = g;
                pe = g ? ref_alu(ops1[i1]) : ref_alu(ops0[i0]);
                if (g) i1++; else i0++;
                have_prev = 1;
            end
            tick();
            set_req(0, 1'b0, idle);
            set_req(1, 1'b0, idle);
            #4;
            chk("rr_last_valid", get_rv(pp), 1);
            chk("rr_last_out", get_out(pp), pe);
        end

        // backpressure on requester 0 stalls requester 1
        do_reset();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        tick();
        set_req(0, 1'b1, mk(4'b0000, 32'd1, 32'd1));
        #4;
        chk("bp_accept0", req0_ready, 1);
        tick();
        set_req(0, 1'b0, idle);
        set_req(1, 1'b1, mk(4'b0000, 32'd3, 32'd4));
        for (int k = 0; k < 3; k++) begin
            #4;
            chk("bp_rsp0_valid", rsp0_valid, 1);
            chk("bp_rsp0_out", rsp0_out, 32'd2);
            chk("bp_req1_stall", req1_ready, 0);
            tick();
        end
        rsp0_ready = 1'b1;
        #4;
        chk("bp_refill_ready", req1_ready, 1);
        chk("bp_drain_valid", rsp0_valid, 1);
        tick();
        set_req(1, 1'b0, idle);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #4;
        chk("bp_rsp1_valid", rsp1_valid, 1);
        chk("bp_rsp1_out", rsp1_out, 32'd7);
        chk("bp_rsp0_gone", rsp0_valid, 0);
        tick();
        #4;
        chk("bp_rsp1_hold", rsp1_out, 32'd7);
        tick();
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        #4;
        chk("drain_rsp1_valid", rsp1_valid, 0);
        chk("drain_rsp1_out", rsp1_out, 0);

        // reset while a result is held
        tick();
        set_req(0, 1'b1, mk(4'b0000, 32'd9, 32'd9));
        tick();
        set_req(0, 1'b0, idle);
        #4;
        chk("mid_rsp0_held", rsp0_valid, 1);
        do_reset();
        #4;
        chk("mid_rsp0_valid", rsp0_valid, 0);
        chk("mid_rsp0_out", rsp0_out, 0);
        chk("mid_rsp1_valid", rsp1_valid, 0);
        tick();
        set_req(0, 1'b1, mk(4'b0000, 32'd1, 32'd2));
        set_req(1, 1'b1, mk(4'b0000, 32'd3, 32'd4));
        #4;
        chk("mid_first_grant0", req0_ready, 1);
        chk("mid_first_grant1", req1_ready, 0);

        // randomized traffic against a transaction-level model
        do_reset();
        begin
            bit busy, own, last, g;
            bit pend [2];
            op_t pop [2];
            logic [31:0] mval;
            logic [1:0] eg, rr;
            bit can;
            busy = 0; own = 0; last = 1; mval = '0;
            pend = '{0, 0};
            pop = '{idle, idle};
            for (int cyc = 0; cyc < 400; cyc++) begin
                tick();
                for (int p = 0; p < 2; p++) begin
                    if (!pend[p] && $urandom_range(0, 1) == 1) begin
                        pend[p] = 1;
                        pop[p] = rand_op();
                    end
                    set_req(p[0], pend[p], pop[p]);
                end
                rsp0_ready = ($urandom_range(0, 9) < 7);
                rsp1_ready = ($urandom_range(0, 9) < 7);
                #4;
                rr = {rsp1_ready, rsp0_ready};
                can = !busy || rr[own];
                eg = 2'b00;
                if (can) begin
                    if (pend[0] && pend[1]) eg = last ? 2'b01 : 2'b10;
                    else eg = {pend[1], pend[0]};
                end
                chk("rnd_ready0", req0_ready, eg[0]);
                chk("rnd_ready1", req1_ready, eg[1]);
                chk("rnd_rsp0_valid", rsp0_valid, busy && !own);
                chk("rnd_rsp1_valid", rsp1_valid, busy && own);
                chk("rnd_rsp0_out", rsp0_out, (busy && !own) ? mval : 32'd0);
                chk("rnd_rsp1_out", rsp1_out, (busy && own) ? mval : 32'd0);
                chk("rnd_rsp0_zero", rsp0_zero, busy && !own && mval == 0);
                chk("rnd_rsp1_zero", rsp1_zero, busy && own && mval == 0);
                if (busy && rr[own]) busy = 0;
                if (eg != 2'b00) begin
                    g = eg[1];
                    busy = 1;
                    own = g;
                    mval = ref_alu(pop[g]);
                    last = g;
                    pend[g] = 0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
